axi2apb_wr_buf: RTL and testbench

Write-response channel of the AXI-to-APB bridge with a parametrised response queue. Every completed APB write (psel, penable, pwrite, pready high together) is converted to an AXI B response (BID, BRESP) and pushed into a RESP_DEPTH-entry FIFO. The AXI master can therefore hold BREADY low while the bridge keeps issuing APB writes. The bridge main FSM uses resp_full to stop starting new APB writes when no queue space is left.

---
 rtl/axi2apb_wr_buf.sv | 109 ++++++++++
 tb/tb_axi2apb_wr_buf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2apb_wr_buf.sv
// Write-response queue of the AXI-to-APB bridge: completed APB writes become AXI B responses
// held in a RESP_DEPTH-entry FIFO so the AXI master may stall BREADY independently.
module axi2apb_wr_buf #(
  parameter int unsigned AXI_ID_WIDTH = 6,
  parameter int unsigned RESP_DEPTH   = 4,
  parameter logic [1:0]  CMD_ERR_RESP = 2'b10,
  parameter logic [1:0]  PSLVERR_RESP = 2'b11
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            psel,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic                            pready,
  input  logic                            pslverr,
  input  logic                            cmd_err,
  input  logic [AXI_ID_WIDTH-1:0]         cmd_id,
  output logic                            WREADY,
  output logic                            finish_wr,
  output logic [AXI_ID_WIDTH-1:0]         BID,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  output logic                            resp_full,
  output logic [$clog2(RESP_DEPTH+1)-1:0] resp_count,
  output logic                            ovf_err
);

  localparam int unsigned PW = $clog2(RESP_DEPTH);
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned EW = AXI_ID_WIDTH + 2;

  logic [EW-1:0] r_mem [RESP_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_d;
  logic          r_ovf;

  logic          w_push, w_pop, w_accept, w_drop;
  logic [1:0]    w_resp;
  logic [EW-1:0] w_entry;

  assign w_push = psel & penable & pwrite & pready;
  assign w_pop  = BVALID & BREADY;

  // A full queue can still take a push when the head is popped on the same edge.
  assign w_accept = w_push & (~resp_full | w_pop);
  assign w_drop   = w_push & resp_full & ~w_pop;

  always_comb begin
    w_resp = 2'b00;
    if (cmd_err) begin
      w_resp = CMD_ERR_RESP;
    end else if (pslverr) begin
      w_resp = PSLVERR_RESP;
    end
  end

  assign w_entry = {cmd_id, w_resp};

  always_comb begin
    w_count_d = r_count;
    unique case ({w_accept, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(RESP_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_d;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // The head only moves on pop, so BID/BRESP stay stable while BREADY is low.
  assign BID        = r_mem[r_rd_ptr][EW-1:2];
  assign BRESP      = r_mem[r_rd_ptr][1:0];
  assign BVALID     = (r_count != '0);
  assign resp_full  = (r_count == CW'(RESP_DEPTH));
  assign resp_count = r_count;
  assign ovf_err    = r_ovf;
  assign WREADY     = w_push;
  assign finish_wr  = w_pop;

endmodule

// File: tb/tb_axi2apb_wr_buf.sv
// Directed bench for axi2apb_wr_buf: inputs change after the falling edge, outputs are
// checked 1 time unit later, well away from the rising edge.
module tb_axi2apb_wr_buf;

  localparam int unsigned IDW   = 6;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           psel, penable, pwrite, pready, pslverr, cmd_err;
  logic [IDW-1:0] cmd_id;
  logic           WREADY, finish_wr, BVALID, BREADY, resp_full, ovf_err;
  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic [2:0]     resp_count;

  int n_checks = 0;
  int n_errors = 0;

  axi2apb_wr_buf #(
    .AXI_ID_WIDTH(IDW),
    .RESP_DEPTH  (DEPTH),
    .CMD_ERR_RESP(2'b10),
    .PSLVERR_RESP(2'b11)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pready    (pready),
    .pslverr   (pslverr),
    .cmd_err   (cmd_err),
    .cmd_id    (cmd_id),
    .WREADY    (WREADY),
    .finish_wr (finish_wr),
    .BID       (BID),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .resp_full (resp_full),
    .resp_count(resp_count),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic ce, input logic se);
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    pready  = 1'b1;
    cmd_id  = id;
    cmd_err = ce;
    pslverr = se;
  endtask

  task automatic idle();
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    pready  = 1'b0;
    cmd_err = 1'b0;
    pslverr = 1'b0;
    cmd_id  = '0;
  endtask

  // Leaves the queue holding IDs 1..4 with BREADY low.
  task automatic fill4();
    BREADY = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push(IDW'(i), 1'b0, 1'b0);
      tick();
    end
    idle();
  endtask

  initial begin
    rstn   = 1'b0;
    BREADY = 1'b0;
    idle();
    #3;
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bid", BID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_count", resp_count, 0);
    chk("rst_full", resp_full, 0);
    chk("rst_ovf", ovf_err, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Single OK write
    BREADY = 1'b1;
    push(6'h15, 1'b0, 1'b0);
    #1;
    chk("ok_wready", WREADY, 1);
    chk("ok_bvalid_pre", BVALID, 0);
    tick();
    idle();
    #1;
    chk("ok_bvalid", BVALID, 1);
    chk("ok_bid", BID, 6'h15);
    chk("ok_bresp", BRESP, 2'b00);
    chk("ok_finish", finish_wr, 1);
    chk("ok_wready_low", WREADY, 0);
    tick();
    chk("ok_bvalid_off", BVALID, 0);
    chk("ok_finish_off", finish_wr, 0);

    // Error priority: cmd_err over pslverr
    push(6'h01, 1'b1, 1'b1);
    tick();
    push(6'h02, 1'b0, 1'b1);
    #1;
    chk("pri_resp0", BRESP, 2'b10);
    tick();
    push(6'h03, 1'b0, 1'b0);
    #1;
    chk("pri_resp1", BRESP, 2'b11);
    chk("pri_count1", resp_count, 1);
    tick();
    idle();
    #1;
    chk("pri_resp2", BRESP, 2'b00);
    chk("pri_bid2", BID, 6'h03);
    tick();
    chk("pri_empty", BVALID, 0);

    // Fill and back-pressure
    fill4();
    chk("fill_count", resp_count, 4);
    chk("fill_full", resp_full, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_bid", BID, 1);
      chk("bp_bresp", BRESP, 0);
      chk("bp_bvalid", BVALID, 1);
      tick();
    end
    BREADY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_bid", BID, i);
      chk("drain_count", resp_count, 5 - i);
      chk("drain_finish", finish_wr, 1);
      tick();
    end
    chk("drain_empty_count", resp_count, 0);
    chk("drain_empty_valid", BVALID, 0);

    // Full plus simultaneous push and pop
    fill4();
    push(6'h05, 1'b0, 1'b0);
    BREADY = 1'b1;
    #1;
    chk("pp_wready", WREADY, 1);
    chk("pp_finish", finish_wr, 1);
    tick();
    idle();
    #1;
    chk("pp_count", resp_count, 4);
    chk("pp_ovf", ovf_err, 0);
    for (int i = 2; i <= 5; i++) begin
      chk("pp_drain_bid", BID, i);
      tick();
    end
    chk("pp_empty", resp_count, 0);

    // Overflow: ID 9 must be dropped
    fill4();
    push(6'h09, 1'b0, 1'b0);
    #1;
    chk("ovf_wready", WREADY, 1);
    tick();
    idle();
    #1;
    chk("ovf_set", ovf_err, 1);
    chk("ovf_count", resp_count, 4);
    chk("ovf_bid", BID, 1);
    BREADY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("ovf_drain_bid", BID, i);
      tick();
    end
    chk("ovf_drained", resp_count, 0);
    chk("ovf_sticky", ovf_err, 1);
    tick();
    chk("ovf_sticky2", ovf_err, 1);

    // Reset mid-operation
    BREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(IDW'(6'h21 + i), 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("mid_count", resp_count, 3);
    chk("mid_bid", BID, 6'h21);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_bvalid", BVALID, 0);
    chk("arst_count", resp_count, 0);
    chk("arst_ovf", ovf_err, 0);
    chk("arst_bid", BID, 0);
    chk("arst_full", resp_full, 0);
    tick();
    rstn   = 1'b1;
    BREADY = 1'b1;
    tick();
    // 2*DEPTH pushes wrap both pointers twice; each entry is popped the cycle it appears.
    for (int i = 0; i < 2 * int'(DEPTH); i++) begin
      push(IDW'(6'h30 + i), (i % 3) == 1, (i % 3) == 2);
      tick();
      idle();
      #1;
      chk("wrap_bvalid", BVALID, 1);
      chk("wrap_bid", BID, 6'h30 + i);
      chk("wrap_bresp", BRESP, ((i % 3) == 1) ? 2'b10 : (((i % 3) == 2) ? 2'b11 : 2'b00));
      chk("wrap_count", resp_count, 1);
    end
    tick();
    chk("wrap_empty", BVALID, 0);
    chk("wrap_ovf", ovf_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
